traffic_light_ctrl: RTL

Parametrised two-road traffic-light controller. It succeeds the fixed-timing intersection controller.
- Configurable phase durations and tick prescaler.
- Per-phase countdown output for a 7-seg display.
- Night (flashing-yellow) mode and an enable/freeze input.
- Optional pedestrian-request green shortening.
- Sits between the board clock and the LED/display driver.

---
 rtl/traffic_pkg.sv | 57 +++++
 rtl/tick_gen.sv | 28 ++
 rtl/traffic_light_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding, LED patterns and phase sequencing for traffic_light_ctrl
package traffic_pkg;

    typedef enum logic [2:0] {
        S_GA    = 3'd0,
        S_YA    = 3'd1,
        S_RR1   = 3'd2,
        S_GB    = 3'd3,
        S_YB    = 3'd4,
        S_RR2   = 3'd5,
        S_NIGHT = 3'd6
    } state_t;

    // Lamp position inside one road's {R,Y,G} triple, and each road's offset in LED
    localparam int BIT_R  = 2;
    localparam int BIT_Y  = 1;
    localparam int BIT_G  = 0;
    localparam int ROAD_A = 3;
    localparam int ROAD_B = 0;

    localparam logic [5:0] LED_GA  = 6'b001_100;
    localparam logic [5:0] LED_YA  = 6'b010_100;
    localparam logic [5:0] LED_RR1 = 6'b100_100;
    localparam logic [5:0] LED_GB  = 6'b100_001;
    localparam logic [5:0] LED_YB  = 6'b100_010;
    localparam logic [5:0] LED_RR2 = 6'b100_100;

    function automatic state_t next_phase(input state_t s);
        case (s)
            S_GA:    return S_YA;
            S_YA:    return S_RR1;
            S_RR1:   return S_GB;
            S_GB:    return S_YB;
            S_YB:    return S_RR2;
            default: return S_GA;
        endcase
    endfunction

    function automatic logic [5:0] led_pattern(input state_t s, input logic flash);
        logic [5:0] p;
        p = '0;
        case (s)
            S_GA:    p = LED_GA;
            S_YA:    p = LED_YA;
            S_RR1:   p = LED_RR1;
            S_GB:    p = LED_GB;
            S_YB:    p = LED_YB;
            S_RR2:   p = LED_RR2;
            default: begin
                p[ROAD_A + BIT_Y] = flash;
                p[ROAD_B + BIT_Y] = flash;
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - countdown tick prescaler, one-cycle tick every TICK_DIV enabled cycles
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Tick fires on the wrap cycle so the consumer acts on the same edge the count returns to 0
    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-road traffic light FSM with countdown; PED_REQ_EN enables pedestrian green shortening
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 6,
    parameter int GREEN_A  = 25,
    parameter int GREEN_B  = 20,
    parameter int YELLOW   = 3,
    parameter int ALL_RED  = 2,
    parameter int PED_MIN  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             night,
    input  logic             ped_req,
    output logic [5:0]       LED,
    output logic [CNT_W-1:0] dem,
    output logic [2:0]       phase,
    output logic             ped_ack
);

    state_t           state, state_n;
    logic [CNT_W-1:0] dem_n;
    logic             flash, flash_n;
    logic             ack_n;
    logic             clr;
    logic             tick;
    logic             ped_hit;

    function automatic logic [CNT_W-1:0] duration(input state_t s);
        case (s)
            S_GA:         return CNT_W'(GREEN_A);
            S_GB:         return CNT_W'(GREEN_B);
            S_YA, S_YB:   return CNT_W'(YELLOW);
            S_RR1, S_RR2: return CNT_W'(ALL_RED);
            default:      return '0;
        endcase
    endfunction

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .tick (tick)
    );

`ifdef PED_REQ_EN
    assign ped_hit = ped_req && en && !night && (state == S_GA || state == S_GB)
                     && (dem > CNT_W'(PED_MIN));
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign ped_hit    = 1'b0;
`endif

    assign phase = state;

    // Night entry/exit beats everything but reset, then pedestrian load beats the tick
    always_comb begin
        state_n = state;
        dem_n   = dem;
        flash_n = flash;
        ack_n   = 1'b0;
        clr     = 1'b0;
        if (state == S_NIGHT) begin
            if (!night) begin
                state_n = S_RR2;
                dem_n   = duration(S_RR2);
                flash_n = 1'b0;
                clr     = 1'b1;
            end else if (tick) begin
                flash_n = !flash;
            end
        end else if (night) begin
            state_n = S_NIGHT;
            dem_n   = '0;
            flash_n = 1'b0;
            clr     = 1'b1;
        end else if (ped_hit) begin
            dem_n = CNT_W'(PED_MIN);
            ack_n = 1'b1;
        end else if (tick) begin
            if (dem == CNT_W'(1)) begin
                state_n = next_phase(state);
                dem_n   = duration(next_phase(state));
            end else begin
                dem_n = dem - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_GA;
            dem     <= CNT_W'(GREEN_A);
            flash   <= 1'b0;
            LED     <= LED_GA;
            ped_ack <= 1'b0;
        end else begin
            state   <= state_n;
            dem     <= dem_n;
            flash   <= flash_n;
            LED     <= led_pattern(state_n, flash_n);
            ped_ack <= ack_n;
        end
    end

endmodule
